// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, fetch states,
// instruction width and the branch-offset helper used by next-PC logic.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_t;

  // Sign-extended immediate scaled to a byte offset (word-aligned by construction).
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave). Read data is valid with ack.
interface if_stage_if;
  import mips_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection for the fetch stage. Priority: jump, then taken beq,
// then the sequential pc+4. All sources are word-aligned, so pc[1:0] stays 0.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]        pc_plus4,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [31:0]        next_pc
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [5:0]  unused_opcode;

  assign branch_target = pc_plus4 + branch_offset(instr[15:0]);
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign unused_opcode = instr[31:26];

  // Pick the next PC source with jump taking precedence over a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the architectural PC, fetches one
// instruction per step over the imem req/ack bus and commits the next PC
// when the datapath reports exec_done.
// Optional: define IF_FETCH_TIMEOUT_EN to add a fetch timeout that parks
// the stage in an error state (fetch_err) until reset.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  if_stage_if.master         imem,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  input  logic               exec_done
`ifdef IF_FETCH_TIMEOUT_EN
  ,
  output logic               fetch_err
`endif
);

  fetch_state_t state, state_nx;
  logic [31:0]  next_pc;
  logic         fetching;

  assign fetching       = (state == S_REQ) || (state == S_WAIT);
  assign pc_plus4       = pc + 32'd4;
  assign opcode         = instr[31:26];
  assign imem.imem_addr = pc;

  next_pc_calc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );

`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wait_cnt;
  logic        timed_out;

  assign timed_out = (wait_cnt == TIMEOUT_LAST);

  // Count fetch cycles without ack; restart whenever a new fetch begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_EXEC && exec_done) begin
      wait_cnt <= '0;
    end else if (fetching && !imem.imem_ack) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  logic        timed_out;
  logic [31:0] unused_timeout;

  assign timed_out      = 1'b0;
  assign unused_timeout = 32'(TIMEOUT_CYC);
`endif

  // State register; reset restarts the fetch from the request state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic for the fetch handshake and execute hand-off.
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ, S_WAIT: begin
        if (imem.imem_ack) begin
          state_nx = S_EXEC;
        end else if (timed_out) begin
          state_nx = S_ERR;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_nx = S_REQ;
        end
      end
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_REQ;
    endcase
  end

  // Outputs decoded from state; the request is gated by reset so it drops at once.
  always_comb begin
    imem.imem_req = rst_n && fetching;
    instr_valid   = (state == S_EXEC);
`ifdef IF_FETCH_TIMEOUT_EN
    fetch_err     = (state == S_ERR);
`endif
  end

  // Latch the fetched instruction on ack and commit the PC on exec_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (fetching && imem.imem_ack) begin
        instr <= imem.imem_rdata;
      end
      if (state == S_EXEC && exec_done) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with RESET_PC=32'h3000, TIMEOUT_CYC=4.
// Honors IF_FETCH_TIMEOUT_EN to exercise the fetch-timeout error state.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        exec_done;
`ifdef IF_FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int vectors;
  int miscompares;

  logic [31:0] expPc;
  logic [31:0] lastInstr;

  typedef struct {
    logic [31:0] rdata;
    int          ackDelay;
    int          execHold;
    logic        br;
    logic        jmp;
    logic        zr;
    logic [31:0] expNext;
  } vec_t;

  vec_t vecs[10];

  if_stage_if imem ();

  if_stage #(
    .RESET_PC    (RST_PC),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .exec_done   (exec_done)
`ifdef IF_FETCH_TIMEOUT_EN
    ,
    .fetch_err   (fetch_err)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the flow ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural next-PC rule computed with plain arithmetic.
  function automatic logic [31:0] refNext(input logic [31:0] curPc, input logic [31:0] ins,
                                          input logic br, input logic jmp, input logic zr);
    logic [31:0] seq;
    int          off;
    seq = curPc + 32'd4;
    off = $signed(ins[15:0]);
    if (jmp) return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    if (br && zr) return seq + 32'(off * 4);
    return seq;
  endfunction

  // Fetch one word at expPc with the given ack latency and check the hand-off.
  task automatic fetchPhase(input logic [31:0] rd, input int delay);
    for (int k = 0; k < delay; k++) begin
      imem.imem_ack = 1'b0;
      checkOutput("req_wait", imem.imem_req, 1);
      checkOutput("addr_hold", imem.imem_addr, expPc);
      checkOutput("valid_low_wait", instr_valid, 0);
      tick();
    end
    checkOutput("req_at_ack", imem.imem_req, 1);
    checkOutput("addr_at_ack", imem.imem_addr, expPc);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = rd;
    tick();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = $urandom;
    lastInstr = rd;
    checkOutput("valid_exec", instr_valid, 1);
    checkOutput("instr_latched", instr, rd);
    checkOutput("opcode", 32'(opcode), 32'(rd[31:26]));
    checkOutput("req_low_exec", imem.imem_req, 0);
    checkOutput("pc_exec", pc, expPc);
    checkOutput("pc_plus4", pc_plus4, expPc + 32'd4);
  endtask

  // Hold in EXEC (with noise on ignored inputs), then commit and check the next fetch.
  task automatic execPhase(input logic br, input logic jmp, input logic zr,
                           input int hold, input logic [31:0] newPc);
    for (int k = 0; k < hold; k++) begin
      branch        = 1'($urandom);
      jump          = 1'($urandom);
      zero          = 1'($urandom);
      exec_done     = 1'b0;
      imem.imem_ack = 1'($urandom);
      tick();
      checkOutput("valid_hold", instr_valid, 1);
      checkOutput("instr_hold", instr, lastInstr);
    end
    imem.imem_ack = 1'b0;
    branch    = br;
    jump      = jmp;
    zero      = zr;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    zero      = 1'b0;
    expPc     = newPc;
    checkOutput("next_req", imem.imem_req, 1);
    checkOutput("next_addr", imem.imem_addr, expPc);
    checkOutput("valid_cleared", instr_valid, 0);
    checkOutput("pc_low_bits", 32'(pc[1:0]), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    fetchPhase(v.rdata, v.ackDelay);
    execPhase(v.br, v.jmp, v.zr, v.execHold, v.expNext);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    //           rdata          ack hold br  j   z   next pc
    vecs[0] = '{32'h1000_FFFF, 1, 0, 1'b1, 1'b0, 1'b1, 32'h0000_3004};
    vecs[1] = '{32'h1000_FFFF, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0000_3008};
    vecs[2] = '{32'h2008_0005, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0000_300C};
    vecs[3] = '{32'h8C08_0000, 2, 2, 1'b0, 1'b0, 1'b0, 32'h0000_3010};
    vecs[4] = '{32'h0800_0C00, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_3000};
    vecs[5] = '{32'h1000_F3FE, 1, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};
    vecs[6] = '{32'hAC08_0000, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[7] = '{32'h1000_FFF0, 2, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFC4};
    vecs[8] = '{32'h0800_0010, 0, 0, 1'b0, 1'b1, 1'b0, 32'hF000_0040};
    vecs[9] = '{32'h1000_0003, 1, 0, 1'b0, 1'b0, 1'b1, 32'hF000_0044};

    rst_n           = 1'b0;
    branch          = 1'b0;
    jump            = 1'b0;
    zero            = 1'b0;
    exec_done       = 1'b0;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h0000_0020;
    tick();
    tick();
    checkOutput("rst_req", imem.imem_req, 0);
    checkOutput("rst_pc", pc, RST_PC);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_valid", instr_valid, 0);
`ifdef IF_FETCH_TIMEOUT_EN
    checkOutput("rst_fetch_err", fetch_err, 0);
`endif

    // Release with ack tied high: request visible at once, instruction one cycle later.
    rst_n = 1'b1;
    #1;
    expPc = RST_PC;
    checkOutput("first_req", imem.imem_req, 1);
    checkOutput("first_addr", imem.imem_addr, RST_PC);
    checkOutput("first_valid_low", instr_valid, 0);
    tick();
    imem.imem_ack = 1'b0;
    lastInstr = 32'h0000_0020;
    checkOutput("first_valid", instr_valid, 1);
    checkOutput("first_instr", instr, 32'h0000_0020);
    execPhase(1'b0, 1'b0, 1'b0, 0, 32'h0000_3004);

    // Directed table: branch taken/not, ADDI with delayed ack, jump priority, wrap-around.
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Randomized fetch/execute steps against the reference rule.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] rd;
      logic        br, jmp, zr;
      rd  = $urandom;
      br  = 1'($urandom);
      zr  = 1'($urandom);
      jmp = ($urandom_range(0, 3) == 0);
      fetchPhase(rd, $urandom_range(0, 3));
      execPhase(br, jmp, zr, $urandom_range(0, 2), refNext(expPc, rd, br, jmp, zr));
    end

    // Reset while waiting for ack: request drops immediately, pending ack discarded.
    imem.imem_ack = 1'b0;
    tick();
    tick();
    checkOutput("wait_req", imem.imem_req, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("req_async_drop", imem.imem_req, 0);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    checkOutput("abort_pc", pc, RST_PC);
    checkOutput("abort_valid", instr_valid, 0);
    checkOutput("abort_instr", instr, 0);
    imem.imem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    expPc = RST_PC;
    checkOutput("restart_req", imem.imem_req, 1);
    checkOutput("restart_addr", imem.imem_addr, RST_PC);
    fetchPhase(32'h2008_0005, 0);
    execPhase(1'b0, 1'b0, 1'b0, 0, 32'h0000_3004);

`ifdef IF_FETCH_TIMEOUT_EN
    // No ack at all: error after four cycles, then a late ack is ignored.
    imem.imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("pre_timeout_err", fetch_err, 0);
      checkOutput("pre_timeout_req", imem.imem_req, 1);
    end
    tick();
    checkOutput("timeout_err", fetch_err, 1);
    checkOutput("timeout_req", imem.imem_req, 0);
    checkOutput("timeout_valid", instr_valid, 0);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h1234_5678;
    tick();
    tick();
    imem.imem_ack = 1'b0;
    checkOutput("late_ack_err", fetch_err, 1);
    checkOutput("late_ack_valid", instr_valid, 0);
    checkOutput("late_ack_req", imem.imem_req, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the single-cycle MIPS core; sits directly upstream of the main control decoder.
- Holds the architectural PC and fetches one instruction per step over a req/ack handshake to instruction memory.
- Presents the latched instruction and its opcode to the decoder and datapath.
- Commits the next PC (sequential, beq-taken or jump) when the datapath signals completion.

Parameters:
- RESET_PC, 32'h0000_0000, PC after reset; must be word-aligned.
- TIMEOUT_CYC, 16, cycles in WAIT without ack before fetch error; used only with IF_FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  memory ack; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- opcode  out  6  instr[31:26], fed to the control decoder.
- instr_valid  out  1  instr is valid for execution.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4.
- branch  in  1  decoder branch (beq).
- jump  in  1  decoder jump.
- zero  in  1  ALU zero flag.
- exec_done  in  1  datapath finished the current instruction; commits the next PC.
- fetch_err  out  1  fetch timeout; present only with IF_FETCH_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release) sets: state=REQ, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0.
- REQ state:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - imem_ack=1 in the same cycle: latch instr=imem_rdata, go to EXEC. Minimum fetch latency is 1 cycle.
  - imem_ack=0: go to WAIT.
- WAIT state:
  - imem_req stays 1 and the address is held.
  - On imem_ack, latch the instruction and go to EXEC.
- EXEC state:
  - instr_valid=1 and imem_req=0.
  - instr is held stable until exec_done.
  - On exec_done: pc <= next_pc, instr_valid <= 0, go to REQ. The next request is issued in the following cycle.
- imem_ack outside REQ/WAIT is ignored. exec_done outside EXEC is ignored.
- next_pc, with priority jump > (branch & zero) > sequential:
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch & zero: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - otherwise: pc_plus4.
  - If jump and branch are both set, jump wins.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. A negative offset below 0 also wraps.
- pc[1:0] is always 2'b00, because every next_pc source is word-aligned.
- opcode is driven from the latched instr, never from imem_rdata directly.
- Reset asserted mid-fetch or mid-exec aborts immediately. imem_req drops asynchronously and the pending ack is discarded.

Optional Feature:
- Macro: IF_FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT without ack.
  - When it reaches TIMEOUT_CYC, go to ERR: imem_req=0, fetch_err=1, instr_valid=0.
  - ERR is held until reset.
- Undefined: no counter, no ERR state, no fetch_err port; WAIT waits forever.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010, OP_ADDI=6'b001000, OP_ANDI=6'b001100.
  - The fetch state encoding (REQ, WAIT, EXEC, ERR).
  - Constant INSTR_W=32.
- One combinational sub-module, next_pc_calc: inputs pc_plus4, instr, branch, jump, zero; output next_pc.

Test Plan:
- Reset with RESET_PC=32'h3000, ack tied high -> imem_req high with imem_addr=32'h3000 on the first cycle after release; instr_valid 1 cycle later.
- Ack delayed 3 cycles, rdata=32'h2008_0005 -> imem_addr stays 32'h3000 for 4 cycles, opcode=6'b001000, instr_valid only after ack.
- pc=32'h3004, instr=32'h1000_FFFF, branch=1, zero=1, exec_done -> next fetch address 32'h3004; with zero=0 -> 32'h3008.
- pc=32'h3010, instr=32'h0800_0C00, jump=1 and branch=1 with zero=1, exec_done -> next address 32'h0000_3000 (jump wins).
- pc=32'hFFFF_FFFC, sequential step -> next address 32'h0000_0000; rst_n pulsed low while in WAIT -> imem_req drops the same cycle and the fetch restarts at RESET_PC.
- IF_FETCH_TIMEOUT_EN, TIMEOUT_CYC=4, ack never asserted -> fetch_err=1 and imem_req=0 after 4 cycles; a late ack is ignored.
